// File: rtl/scale_arbiter_if.sv
// Requester/result handshake bundle for the shared constant-scale unit.
// The master side issues operands and drains results; the slave side is the arbiter.
interface scale_arbiter_if #(
    parameter int N_REQ = 4
) ();
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
    logic               res_valid;
    logic               res_ready;
    logic signed [7:0]  res_data;
    logic [ID_W-1:0]    res_id;
    logic               busy;

    modport master (
        output req_valid, req_data, res_ready,
        input  req_ready, res_valid, res_data, res_id, busy
    );

    modport slave (
        input  req_valid, req_data, res_ready,
        output req_ready, res_valid, res_data, res_id, busy
    );
endinterface

// File: rtl/scale_arbiter.sv
// Round-robin arbiter in front of a three-stage signed constant-scale pipeline.
// Each result leaves tagged with the ID of the requester whose operand produced it.
module scale_arbiter #(
    parameter int                N_REQ = 4,
    parameter logic signed [7:0] COEF  = 8'sd19,
    parameter int                FRAC  = 6
) (
    input  logic           clk,
    input  logic           rst,
    scale_arbiter_if.slave bus
);
    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ID_W   = $clog2(N_REQ);
    localparam logic [ID_W:0] N_WRAP = (ID_W + 1)'(N_REQ);

    logic [ID_W-1:0]          ptr;
    logic [N_REQ-1:0]         grant;
    logic [ID_W-1:0]          grant_id;
    logic [ID_W-1:0]          cand;
    logic                     grant_any;
    logic                     adv;
    logic                     accept;

    logic signed [DATA_W-1:0] data_p0;
    logic [ID_W-1:0]          id_p0;
    logic                     vld_p0;
    logic signed [PROD_W-1:0] prod_p1;
    logic [ID_W-1:0]          id_p1;
    logic                     vld_p1;
    logic signed [DATA_W-1:0] data_p2;
    logic [ID_W-1:0]          id_p2;
    logic                     vld_p2;

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                 input logic [ID_W-1:0] offs);
        logic [ID_W:0] sum;
        sum = {1'b0, base} + {1'b0, offs};
        if (sum >= N_WRAP) sum = sum - N_WRAP;
        return sum[ID_W-1:0];
    endfunction

    // Keeping bits [FRAC+7:FRAC] of the product is an arithmetic shift that floors.
    function automatic logic signed [DATA_W-1:0] scale_floor(input logic signed [PROD_W-1:0] prod);
        return prod[FRAC +: DATA_W];
    endfunction

    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = wrap_add(ptr, k[ID_W-1:0]);
            if (!grant_any && bus.req_valid[cand]) begin
                grant[cand] = 1'b1;
                grant_id    = cand;
                grant_any   = 1'b1;
            end
        end
    end

    // A stalled output freezes the whole pipe, so no operand may be taken either.
    assign adv    = !(vld_p2 && !bus.res_ready);
    assign accept = grant_any && adv && !rst;
    assign bus.req_ready = accept ? grant : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= '0;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            data_p2 <= '0;
            id_p2   <= '0;
        end else if (adv) begin
            if (accept) ptr <= wrap_add(grant_id, ID_W'(1));
            vld_p0 <= accept;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            // S3: output register
            if (vld_p1) begin
                data_p2 <= scale_floor(prod_p1);
                id_p2   <= id_p1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            // S1: operand and ID capture
            if (accept) begin
                data_p0 <= bus.req_data[DATA_W*grant_id +: DATA_W];
                id_p0   <= grant_id;
            end
            // S2: full-width signed product
            if (vld_p0) begin
                prod_p1 <= PROD_W'(data_p0) * PROD_W'(COEF);
                id_p1   <= id_p0;
            end
        end
    end

    assign bus.res_valid = vld_p2;
    assign bus.res_data  = data_p2;
    assign bus.res_id    = id_p2;
    assign bus.busy      = vld_p0 | vld_p1 | vld_p2;
endmodule

// File: tb/tb_scale_arbiter.sv
// Directed and scoreboarded bench for the round-robin constant-scale arbiter.
module tb_scale_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;

    int n_checks = 0;
    int n_errors = 0;

    int d_tab [4] = '{96, -96, 127, -128};
    int e_tab [4] = '{28, -29, 37, -38};
    int left [4];
    int exp_ids [$];

    typedef struct { int id; int val; } sb_item_t;
    sb_item_t   sb_q [$];
    logic [3:0] vld;
    logic [3:0] pend;
    logic [7:0] dat [4];
    int         wait_g [4];
    int         max_wait;
    int         bad_grant;
    int         n_results;

    scale_arbiter_if #(.N_REQ(N)) bus ();

    scale_arbiter #(.N_REQ(N), .COEF(8'sd19), .FRAC(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic int ref_scale(input int d);
        int p;
        int q;
        p = d * 19;
        q = p / 64;
        if (p < 0 && (p % 64) != 0) q = q - 1;
        return q;
    endfunction

    task automatic load_tab();
        for (int i = 0; i < N; i++) bus.req_data[8*i +: 8] = 8'(d_tab[i]);
    endtask

    task automatic drive_left();
        for (int i = 0; i < N; i++) bus.req_valid[i] = (left[i] > 0);
    endtask

    task automatic take_grants();
        for (int i = 0; i < N; i++) if (bus.req_ready[i]) left[i]--;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = '0;
        bus.res_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_single(input string tag, input int id, input int d, input int exp_val);
        int n;
        @(negedge clk);
        bus.res_ready = 1'b1;
        bus.req_data[8*id +: 8] = 8'(d);
        bus.req_valid = '0;
        bus.req_valid[id] = 1'b1;
        #1;
        n = 0;
        while (!bus.req_ready[id] && n < 10) begin @(negedge clk); #1; n++; end
        check({tag, "_grant"}, int'(bus.req_ready[id]), 1);
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        n = 0;
        while (!bus.res_valid && n < 10) begin @(negedge clk); #1; n++; end
        check({tag, "_val"}, $signed(bus.res_data), exp_val);
        check({tag, "_id"}, int'(bus.res_id), id);
    endtask

    task automatic drive_collect(input string tag, input int max_cycles);
        int got_id [$];
        int got_val [$];
        int c_first;
        int c_last;
        int total;
        total   = exp_ids.size();
        c_first = -1;
        c_last  = -1;
        for (int c = 0; c < max_cycles && got_id.size() < total; c++) begin
            @(negedge clk);
            bus.res_ready = 1'b1;
            drive_left();
            #1;
            take_grants();
            if (bus.res_valid) begin
                got_id.push_back(int'(bus.res_id));
                got_val.push_back(int'($signed(bus.res_data)));
                if (c_first < 0) c_first = c;
                c_last = c;
            end
        end
        check({tag, "_count"}, got_id.size(), total);
        for (int k = 0; k < got_id.size() && k < total; k++) begin
            check($sformatf("%s_id%0d", tag, k), got_id[k], exp_ids[k]);
            check($sformatf("%s_val%0d", tag, k), got_val[k], e_tab[exp_ids[k]]);
        end
        check({tag, "_rate"}, c_last - c_first, total - 1);
    endtask

    task automatic sb_cycle(input bit allow_new);
        logic [3:0] rdy;
        sb_item_t   it;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (!pend[i]) begin
                vld[i] = allow_new && ($urandom_range(0, 99) < 55);
                dat[i] = 8'($urandom);
            end
            bus.req_data[8*i +: 8] = dat[i];
        end
        bus.req_valid = vld;
        bus.res_ready = allow_new ? ($urandom_range(0, 99) < 70) : 1'b1;
        #1;
        rdy = bus.req_ready;
        if (bus.res_valid && bus.res_ready) begin
            n_results++;
            check("sb_nonempty", int'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                it = sb_q.pop_front();
                check("sb_id", int'(bus.res_id), it.id);
                check("sb_val", int'($signed(bus.res_data)), it.val);
            end
        end
        if ($countones(rdy) > 1 || (rdy & ~vld) != 4'b0000) bad_grant++;
        if (rdy != 4'b0000) begin
            for (int i = 0; i < N; i++) begin
                if (rdy[i]) begin
                    it.id  = i;
                    it.val = ref_scale(int'($signed(dat[i])));
                    sb_q.push_back(it);
                    if (wait_g[i] > max_wait) max_wait = wait_g[i];
                    wait_g[i] = 0;
                end else if (vld[i]) begin
                    wait_g[i]++;
                end
            end
        end
        pend = vld & ~rdy;
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.res_ready = 1'b0;

        // Reset state
        @(negedge clk);
        #1;
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_data", $signed(bus.res_data), 0);
        check("rst_res_id", int'(bus.res_id), 0);
        check("rst_busy", bus.busy, 0);
        check("rst_req_ready", int'(bus.req_ready), 0);
        @(negedge clk);
        rst = 1'b0;

        // Single request and exact latency
        @(negedge clk);
        bus.req_data[7:0] = 8'd96;
        bus.req_valid = 4'b0001;
        bus.res_ready = 1'b1;
        #1;
        check("t1_ready", int'(bus.req_ready), 1);
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        check("t1_lat1_valid", bus.res_valid, 0);
        check("t1_busy", bus.busy, 1);
        @(negedge clk);
        #1;
        check("t1_lat2_valid", bus.res_valid, 0);
        @(negedge clk);
        #1;
        check("t1_valid", bus.res_valid, 1);
        check("t1_data", $signed(bus.res_data), 28);
        check("t1_id", int'(bus.res_id), 0);
        check("t1_busy_hold", bus.busy, 1);
        @(negedge clk);
        #1;
        check("t1_valid_fall", bus.res_valid, 0);
        check("t1_busy_fall", bus.busy, 0);

        // Arithmetic corners through requester 2
        run_single("t2_m96", 2, -96, -29);
        run_single("t2_127", 2, 127, 37);
        run_single("t2_m128", 2, -128, -38);
        run_single("t2_zero", 2, 0, 0);
        run_single("t2_m1", 2, -1, -1);

        // Fairness: all four, then only 1 and 3
        do_reset();
        load_tab();
        for (int i = 0; i < N; i++) left[i] = 2;
        exp_ids.delete();
        for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) exp_ids.push_back(i);
        drive_collect("t3a", 30);
        left = '{0, 4, 0, 4};
        exp_ids.delete();
        for (int r = 0; r < 4; r++) begin exp_ids.push_back(1); exp_ids.push_back(3); end
        drive_collect("t3b", 30);

        // Backpressure with a full pipeline
        do_reset();
        load_tab();
        for (int i = 0; i < N; i++) left[i] = 2;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.res_ready = 1'b0;
            drive_left();
            #1;
            check($sformatf("t4_fill_grant%0d", c), int'(bus.req_ready), 1 << c);
            take_grants();
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.res_ready = 1'b0;
            drive_left();
            #1;
            check($sformatf("t4_stall_id%0d", c), int'(bus.res_id), 0);
            check($sformatf("t4_stall_val%0d", c), $signed(bus.res_data), 28);
            check($sformatf("t4_stall_ready%0d", c), int'(bus.req_ready), 0);
        end
        exp_ids.delete();
        for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) exp_ids.push_back(i);
        drive_collect("t4", 30);
        repeat (3) @(negedge clk);
        #1;
        check("t4_idle", bus.busy, 0);

        // Reset with three items in flight
        do_reset();
        load_tab();
        for (int i = 0; i < N; i++) left[i] = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.res_ready = 1'b0;
            drive_left();
            #1;
            take_grants();
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_rst_valid", bus.res_valid, 0);
        check("t5_rst_data", $signed(bus.res_data), 0);
        check("t5_rst_id", int'(bus.res_id), 0);
        check("t5_rst_busy", bus.busy, 0);
        check("t5_rst_ready", int'(bus.req_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) left[i] = 1;
        drive_left();
        bus.res_ready = 1'b1;
        #1;
        check("t5_first_grant", int'(bus.req_ready), 1);
        check("t5_no_stale", bus.res_valid, 0);
        take_grants();
        exp_ids.delete();
        for (int i = 0; i < N; i++) exp_ids.push_back(i);
        drive_collect("t5", 20);

        // Random traffic against the reference model
        vld = '0;
        pend = '0;
        max_wait = 0;
        bad_grant = 0;
        n_results = 0;
        for (int i = 0; i < N; i++) begin wait_g[i] = 0; dat[i] = '0; end
        for (int c = 0; c < 2000; c++) sb_cycle(1'b1);
        for (int c = 0; c < 20; c++) sb_cycle(1'b0);
        check("rand_max_wait_ok", int'(max_wait <= N - 1), 1);
        check("rand_bad_grants", bad_grant, 0);
        check("rand_sb_empty", sb_q.size(), 0);
        check("rand_results_seen", int'(n_results > 500), 1);
        check("rand_idle", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
